// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared definitions for the HD44780-style LCD bus monitor:
//               command opcode masks/values, DDRAM address map, blank fill
//               character and address helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    localparam logic [7:0] c_BLANK_CHAR = 8'h20;

    // Command opcodes: the highest set bit selects the command
    localparam logic [7:0] c_CLEAR_MASK   = 8'hFF;
    localparam logic [7:0] c_CLEAR_VAL    = 8'h01;
    localparam logic [7:0] c_HOME_MASK    = 8'hFE;
    localparam logic [7:0] c_HOME_VAL     = 8'h02;
    localparam logic [7:0] c_ENTRY_MASK   = 8'hFC;
    localparam logic [7:0] c_ENTRY_VAL    = 8'h04;
    localparam logic [7:0] c_DISPCTL_MASK = 8'hF8;
    localparam logic [7:0] c_DISPCTL_VAL  = 8'h08;
    localparam logic [7:0] c_SHIFT_MASK   = 8'hF0;
    localparam logic [7:0] c_SHIFT_VAL    = 8'h10;
    localparam logic [7:0] c_FUNCSET_MASK = 8'hE0;
    localparam logic [7:0] c_FUNCSET_VAL  = 8'h20;
    localparam logic [7:0] c_CGRAM_MASK   = 8'hC0;
    localparam logic [7:0] c_CGRAM_VAL    = 8'h40;
    localparam logic [7:0] c_DDRAM_MASK   = 8'h80;
    localparam logic [7:0] c_DDRAM_VAL    = 8'h80;

    // DDRAM address map of a 16x2 panel
    localparam logic [6:0] c_LINE1_BASE = 7'h00;
    localparam logic [6:0] c_LINE2_BASE = 7'h40;
    localparam logic [6:0] c_LINE_LEN   = 7'd16;
    localparam logic [6:0] c_ROW1_END   = 7'h27;
    localparam logic [6:0] c_ROW2_END   = 7'h67;

    typedef enum logic [3:0] {
        CMD_NONE,
        CMD_CLEAR,
        CMD_HOME,
        CMD_ENTRY,
        CMD_DISPCTL,
        CMD_SHIFT,
        CMD_FUNCSET,
        CMD_CGRAM,
        CMD_DDRAM
    } cmd_e;

    function automatic cmd_e decode_cmd(input logic [7:0] b);
        if ((b & c_DDRAM_MASK)   == c_DDRAM_VAL)   return CMD_DDRAM;
        if ((b & c_CGRAM_MASK)   == c_CGRAM_VAL)   return CMD_CGRAM;
        if ((b & c_FUNCSET_MASK) == c_FUNCSET_VAL) return CMD_FUNCSET;
        if ((b & c_SHIFT_MASK)   == c_SHIFT_VAL)   return CMD_SHIFT;
        if ((b & c_DISPCTL_MASK) == c_DISPCTL_VAL) return CMD_DISPCTL;
        if ((b & c_ENTRY_MASK)   == c_ENTRY_VAL)   return CMD_ENTRY;
        if ((b & c_HOME_MASK)    == c_HOME_VAL)    return CMD_HOME;
        if ((b & c_CLEAR_MASK)   == c_CLEAR_VAL)   return CMD_CLEAR;
        return CMD_NONE;
    endfunction

    // Address counter step; rows are 40 cells long and wrap into each other
    function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc);
        if (inc) begin
            if (a == c_ROW1_END) return c_LINE2_BASE;
            if (a == c_ROW2_END) return c_LINE1_BASE;
            return a + 7'd1;
        end
        if (a == c_LINE2_BASE) return c_ROW1_END;
        if (a == c_LINE1_BASE) return c_ROW2_END;
        return a - 7'd1;
    endfunction

    function automatic logic addr_visible(input logic [6:0] a);
        return ((a - c_LINE1_BASE) < c_LINE_LEN) || ((a - c_LINE2_BASE) < c_LINE_LEN);
    endfunction

    // LSB of the byte slot in the 256-bit message; line 1 pos 0 sits at the top
    function automatic logic [7:0] msg_offset(input logic [6:0] a);
        logic [4:0] idx;
        idx = {a[6], a[3:0]};
        return {~idx, 3'b000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_bus_sync.sv
`default_nettype none
// ============================================================================
// Module      : lcd_bus_sync
// Description : Synchronizes the LCD bus into clk_i and detects falling edges
//               of lcd_en, presenting a one-cycle registered strobe together
//               with the rs/rw/data/on values captured at the edge.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   i_lcd_*           : raw bus inputs
//   o_strobe          : one-cycle pulse per accepted falling edge
//   o_on/o_rs/o_rw    : captured control bits
//   o_data            : captured data byte
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       i_lcd_on,
    input  logic       i_lcd_en,
    input  logic       i_lcd_rs,
    input  logic       i_lcd_rw,
    input  logic [7:0] i_lcd_data,
    output logic       o_strobe,
    output logic       o_on,
    output logic       o_rs,
    output logic       o_rw,
    output logic [7:0] o_data
);

    localparam int c_STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    // Packed bus word: [11]=on [10]=en [9]=rs [8]=rw [7:0]=data.
    // The en bit resets high so that a strobe already high at reset release
    // (or the low level shifting in after reset) cannot fake a falling edge.
    localparam logic [11:0] c_SYNC_RST = 12'h400;

    logic [11:0] r_sync [c_STAGES];
    logic        r_en_dly;
    logic        r_armed;
    logic        r_strobe;
    logic        r_on;
    logic        r_rs;
    logic        r_rw;
    logic [7:0]  r_data;
    logic [11:0] w_last;
    logic        w_fall;

    assign w_last = r_sync[c_STAGES-1];
    // Edges count only once en has been seen low after reset
    assign w_fall = r_armed && !w_last[10] && r_en_dly;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < c_STAGES; i++) begin
                r_sync[i] <= c_SYNC_RST;
            end
            r_en_dly <= 1'b1;
            r_armed  <= 1'b0;
            r_strobe <= 1'b0;
            r_on     <= 1'b0;
            r_rs     <= 1'b0;
            r_rw     <= 1'b0;
            r_data   <= 8'h00;
        end else begin
            r_sync[0] <= {i_lcd_on, i_lcd_en, i_lcd_rs, i_lcd_rw, i_lcd_data};
            for (int i = 1; i < c_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_en_dly <= w_last[10];
            if (!r_en_dly) begin
                r_armed <= 1'b1;
            end
            r_strobe <= w_fall;
            if (w_fall) begin
                r_on   <= w_last[11];
                r_rs   <= w_last[9];
                r_rw   <= w_last[8];
                r_data <= w_last[7:0];
            end
        end
    end

    assign o_strobe = r_strobe;
    assign o_on     = r_on;
    assign o_rs     = r_rs;
    assign o_rw     = r_rw;
    assign o_data   = r_data;

endmodule
`default_nettype wire

// File: rtl/lcd_bus_monitor.sv
`default_nettype none
// ============================================================================
// Module      : lcd_bus_monitor
// Description : Passive HD44780-style 8-bit LCD bus decoder. Rebuilds the
//               16x2 DDRAM contents into a 256-bit message word and reports
//               command/data events and protocol errors.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   lcd_*          : monitored LCD bus (lcd_rw read cycles are ignored)
//   mensaje_o      : display image, line 1 pos 0 at [255:248]
//   cmd_valid_o    : pulse per decoded command, cmd_o holds the last one
//   char_valid_o   : pulse per visible character write
//   addr_o         : DDRAM address counter
//   display_on_o   : D bit of last display-control command
//   init_ok_o      : sticky, 8-bit function set seen
//   frame_done_o   : pulse on write to the last cell (0x4F)
//   err_o          : sticky protocol error
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_bus_monitor
    import lcd_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] BLANK_CHAR  = c_BLANK_CHAR
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         lcd_on,
    input  logic         lcd_en,
    input  logic         lcd_rs,
    input  logic         lcd_rw,
    input  logic [7:0]   lcd_data,
    output logic [255:0] mensaje_o,
    output logic         cmd_valid_o,
    output logic [7:0]   cmd_o,
    output logic         char_valid_o,
    output logic [6:0]   addr_o,
    output logic         display_on_o,
    output logic         init_ok_o,
    output logic         frame_done_o,
    output logic         err_o
);

    localparam logic [255:0] c_BLANK_MSG = {32{BLANK_CHAR}};

    logic         w_strobe;
    logic         w_on;
    logic         w_rs;
    logic         w_rw;
    logic [7:0]   w_data;

    logic [255:0] r_msg;
    logic [6:0]   r_addr;
    logic         r_inc;
    logic         r_cgram;
    logic         r_disp;
    logic         r_init;
    logic         r_err;
    logic [7:0]   r_cmd;
    logic         r_cmd_valid;
    logic         r_char_valid;
    logic         r_frame_done;

    lcd_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_lcd_on   (lcd_on),
        .i_lcd_en   (lcd_en),
        .i_lcd_rs   (lcd_rs),
        .i_lcd_rw   (lcd_rw),
        .i_lcd_data (lcd_data),
        .o_strobe   (w_strobe),
        .o_on       (w_on),
        .o_rs       (w_rs),
        .o_rw       (w_rw),
        .o_data     (w_data)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_msg        <= c_BLANK_MSG;
            r_addr       <= 7'h00;
            r_inc        <= 1'b1;
            r_cgram      <= 1'b0;
            r_disp       <= 1'b0;
            r_init       <= 1'b0;
            r_err        <= 1'b0;
            r_cmd        <= 8'h00;
            r_cmd_valid  <= 1'b0;
            r_char_valid <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_cmd_valid  <= 1'b0;
            r_char_valid <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_strobe && w_on && !w_rw) begin
                if (!w_rs) begin
                    r_cmd_valid <= 1'b1;
                    r_cmd       <= w_data;
                    case (decode_cmd(w_data))
                        CMD_DDRAM: begin
                            r_addr  <= w_data[6:0];
                            r_cgram <= 1'b0;
                            // 0x28-0x3F and 0x68-0x7F lie beyond both rows
                            if (w_data[5:0] >= 6'h28) begin
                                r_err <= 1'b1;
                            end
                        end
                        CMD_CGRAM: begin
                            r_cgram <= 1'b1;
                        end
                        CMD_FUNCSET: begin
                            if (w_data == 8'h38 || w_data == 8'h3C) begin
                                r_init <= 1'b1;
                            end
                            if (!w_data[4]) begin
                                r_err <= 1'b1;
                            end
                        end
                        CMD_SHIFT: begin
                            if (w_data[3]) begin
                                r_err <= 1'b1;
                            end else begin
                                r_addr <= addr_step(r_addr, w_data[2]);
                            end
                        end
                        CMD_DISPCTL: begin
                            r_disp <= w_data[2];
                        end
                        CMD_ENTRY: begin
                            r_inc <= w_data[1];
                            if (w_data[0]) begin
                                r_err <= 1'b1;
                            end
                        end
                        CMD_HOME: begin
                            r_addr <= 7'h00;
                        end
                        CMD_CLEAR: begin
                            r_msg  <= c_BLANK_MSG;
                            r_addr <= 7'h00;
                            r_inc  <= 1'b1;
                        end
                        default: begin
                            r_err <= 1'b1;
                        end
                    endcase
                end else if (!r_cgram) begin
                    if (addr_visible(r_addr)) begin
                        r_msg[msg_offset(r_addr) +: 8] <= w_data;
                        r_char_valid <= 1'b1;
                        if (r_addr == 7'h4F) begin
                            r_frame_done <= 1'b1;
                        end
                    end
                    r_addr <= addr_step(r_addr, r_inc);
                end
            end
        end
    end

    assign mensaje_o    = r_msg;
    assign cmd_valid_o  = r_cmd_valid;
    assign cmd_o        = r_cmd;
    assign char_valid_o = r_char_valid;
    assign addr_o       = r_addr;
    assign display_on_o = r_disp;
    assign init_ok_o    = r_init;
    assign frame_done_o = r_frame_done;
    assign err_o        = r_err;

endmodule
`default_nettype wire
